// File: rtl/pong_scoreboard.sv
// Pong scoreboard: ball-window tracking, scoring with point hold, game-over
// detection and a multiplexed four-digit 7-segment display.
//
// state | meaning
// IDLE  | waiting for Begin after reset
// PLAY  | ball in flight; end windows open and close on Tick
// POINT | a point was scored; counting Tick pulses before play resumes
// OVER  | a side reached WIN_SCORE; waiting for Begin
module pong_scoreboard #(
  parameter int WIN_SCORE    = 9,
  parameter int POINT_HOLD   = 4,
  parameter int REFRESH_BITS = 17
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tick,
  input  logic [7:0] Led,
  input  logic       HitL,
  input  logic       HitR,
  input  logic       Begin,
  output logic [3:0] ScoreL,
  output logic [3:0] ScoreR,
  output logic [6:0] Seg,
  output logic [3:0] An,
  output logic       GameOver,
  output logic [1:0] Winner
);

  localparam int HOLD_W = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(POINT_HOLD - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, POINT = 2'd2, OVER = 2'd3} state_t;

  state_t state, state_nxt;
  logic win_l, win_r, win_l_nxt, win_r_nxt;
  logic [3:0] score_l_nxt, score_r_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic [REFRESH_BITS-1:0] refresh;
  logic [1:0] dsel;
  logic [3:0] digit;
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;
  logic left_won, right_won;

  assign left_won  = (ScoreL == WIN);
  assign right_won = (ScoreR == WIN);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= IDLE;
      ScoreL <= '0;
      ScoreR <= '0;
      win_l  <= 1'b0;
      win_r  <= 1'b0;
      hold   <= '0;
    end else begin
      state  <= state_nxt;
      ScoreL <= score_l_nxt;
      ScoreR <= score_r_nxt;
      win_l  <= win_l_nxt;
      win_r  <= win_r_nxt;
      hold   <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    score_l_nxt = ScoreL;
    score_r_nxt = ScoreR;
    win_l_nxt   = win_l;
    win_r_nxt   = win_r;
    hold_nxt    = hold;
    case (state)
      IDLE, OVER: begin
        if (Begin) begin
          state_nxt   = PLAY;
          score_l_nxt = '0;
          score_r_nxt = '0;
          win_l_nxt   = 1'b0;
          win_r_nxt   = 1'b0;
        end
      end
      PLAY: begin
        // A hit in the same cycle as the closing Tick still counts as a return.
        if (win_l) begin
          if (HitL) begin
            win_l_nxt = 1'b0;
          end else if (Tick) begin
            win_l_nxt = 1'b0;
            if (ScoreR < WIN) score_r_nxt = ScoreR + 4'd1;
            hold_nxt  = HOLD_LOAD;
            state_nxt = POINT;
          end
        end else if (win_r) begin
          if (HitR) begin
            win_r_nxt = 1'b0;
          end else if (Tick) begin
            win_r_nxt = 1'b0;
            if (ScoreL < WIN) score_l_nxt = ScoreL + 4'd1;
            hold_nxt  = HOLD_LOAD;
            state_nxt = POINT;
          end
        end else if (Tick) begin
          win_l_nxt = (Led == 8'h80);
          win_r_nxt = (Led == 8'h01);
        end
      end
      POINT: begin
        if (Tick) begin
          if (hold == '0) state_nxt = (left_won || right_won) ? OVER : PLAY;
          else            hold_nxt  = hold - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign GameOver = (state == OVER);
  assign Winner   = (state != OVER) ? 2'b00 :
                    left_won        ? 2'b01 :
                    right_won       ? 2'b10 : 2'b00;

  assign dsel = refresh[REFRESH_BITS-1 -: 2];

  // Code 4'hF falls through the decoder as a blank digit.
  always_comb begin
    an_nxt  = 4'hF;
    digit   = 4'hF;
    seg_nxt = 7'h7F;
    case (dsel)
      2'd0: begin
        an_nxt = 4'b1110;
        digit  = (GameOver && left_won) ? 4'hF : ScoreR;
      end
      2'd1: an_nxt = 4'b1101;
      2'd2: an_nxt = 4'b1011;
      default: begin
        an_nxt = 4'b0111;
        digit  = (GameOver && !left_won) ? 4'hF : ScoreL;
      end
    endcase
    case (digit)
      4'd0:    seg_nxt = 7'b0000001;
      4'd1:    seg_nxt = 7'b1001111;
      4'd2:    seg_nxt = 7'b0010010;
      4'd3:    seg_nxt = 7'b0000110;
      4'd4:    seg_nxt = 7'b1001100;
      4'd5:    seg_nxt = 7'b0100100;
      4'd6:    seg_nxt = 7'b0100000;
      4'd7:    seg_nxt = 7'b0001111;
      4'd8:    seg_nxt = 7'b0000000;
      4'd9:    seg_nxt = 7'b0000100;
      default: seg_nxt = 7'h7F;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      refresh <= '0;
      An      <= 4'hF;
      Seg     <= 7'h7F;
    end else begin
      refresh <= refresh + 1'b1;
      An      <= an_nxt;
      Seg     <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_pong_scoreboard.sv
// Scoreboard bench for pong_scoreboard: a 9-point instance for play, reset and
// display, and a 2-point instance for game-over and winner reporting.
module tb_pong_scoreboard;

  localparam int RB = 6;
  localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_POINT = 2'd2, S_OVER = 2'd3;

  logic clk = 1'b0;
  logic rst, rst2, tick, hitl, hitr, beg;
  logic [7:0] led;
  logic [3:0] score_l, score_r, score_l2, score_r2, an, an2;
  logic [6:0] seg, seg2;
  logic go, go2;
  logic [1:0] win, win2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      tag;
    logic [3:0] sl;
    logic [3:0] sr;
    logic [1:0] st;
  } exp_t;
  exp_t sb[$];

  logic [3:0] exp_l, exp_r, win_sc;
  bit use2;

  always #5 clk = ~clk;

  pong_scoreboard #(.WIN_SCORE(9), .POINT_HOLD(4), .REFRESH_BITS(RB)) dut (
    .Clk(clk), .Rst(rst), .Tick(tick), .Led(led), .HitL(hitl), .HitR(hitr), .Begin(beg),
    .ScoreL(score_l), .ScoreR(score_r), .Seg(seg), .An(an), .GameOver(go), .Winner(win));

  pong_scoreboard #(.WIN_SCORE(2), .POINT_HOLD(4), .REFRESH_BITS(RB)) dut2 (
    .Clk(clk), .Rst(rst2), .Tick(tick), .Led(led), .HitL(hitl), .HitR(hitr), .Begin(beg),
    .ScoreL(score_l2), .ScoreR(score_r2), .Seg(seg2), .An(an2), .GameOver(go2), .Winner(win2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100;  default: return 7'h7F;
    endcase
  endfunction

  task automatic step(input logic t, input logic [7:0] l, input logic hl, input logic hr,
                      input logic b);
    tick = t; led = l; hitl = hl; hitr = hr; beg = b;
    @(posedge clk); #1;
    tick = 1'b0; hitl = 1'b0; hitr = 1'b0; beg = 1'b0;
  endtask

  task automatic pop_chk();
    exp_t e;
    logic [1:0] st;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (use2) begin
      st = dut2.state;
      chk({e.tag, ".l"}, 32'(score_l2), 32'(e.sl));
      chk({e.tag, ".r"}, 32'(score_r2), 32'(e.sr));
    end else begin
      st = dut.state;
      chk({e.tag, ".l"}, 32'(score_l), 32'(e.sl));
      chk({e.tag, ".r"}, 32'(score_r), 32'(e.sr));
    end
    chk({e.tag, ".st"}, 32'(st), 32'(e.st));
  endtask

  // Push the expectation, drive one cycle, then compare against the DUT.
  task automatic sstep(input string tag, input logic [1:0] st, input logic t,
                       input logic [7:0] l, input logic hl, input logic hr, input logic b);
    sb.push_back('{tag, exp_l, exp_r, st});
    step(t, l, hl, hr, b);
    pop_chk();
  endtask

  task automatic hold_seq(input int n);
    logic [1:0] fin;
    fin = (exp_l == win_sc || exp_r == win_sc) ? S_OVER : S_PLAY;
    for (int i = 0; i < n; i++) begin
      sstep("hold", (i == 3) ? fin : S_POINT, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic miss_right();
    sstep("open_r", S_PLAY, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    if (exp_l < win_sc) exp_l = exp_l + 4'd1;
    sstep("miss_r", S_POINT, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic miss_left(input bit wrong_hit);
    sstep("open_l", S_PLAY, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
    if (wrong_hit) sstep("wrong_hit", S_PLAY, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    if (exp_r < win_sc) exp_r = exp_r + 4'd1;
    sstep("miss_l", S_POINT, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_an2(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * (1 << RB) && !ok; i++) begin
      @(posedge clk); #1;
      if (an2 == target) ok = 1'b1;
    end
  endtask

  initial begin
    int prev_d, d, changes, order_bad, seen;
    logic [6:0] seg_d[4];
    bit ok;

    rst = 1'b1; rst2 = 1'b1; tick = 0; hitl = 0; hitr = 0; beg = 0; led = 8'h00;
    exp_l = 4'd0; exp_r = 4'd0; win_sc = 4'd9; use2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.score_l", 32'(score_l), 32'd0);
    chk("rst.score_r", 32'(score_r), 32'd0);
    chk("rst.gameover", 32'(go), 32'd0);
    chk("rst.winner", 32'(win), 32'd0);
    chk("rst.an", 32'(an), 32'hF);
    chk("rst.seg", 32'(seg), 32'h7F);
    chk("rst.state", 32'(dut.state), 32'(S_IDLE));
    rst = 1'b0;

    sstep("idle_tick", S_IDLE, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
    sstep("begin", S_PLAY, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Left return: HitL three cycles after the opening Tick.
    sstep("open_l", S_PLAY, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
    sstep("hit_l", S_PLAY, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0);
    sstep("tick_after_hit", S_PLAY, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0);

    sstep("hit_outside", S_PLAY, 1'b0, 8'h20, 1'b1, 1'b1, 1'b0);
    miss_left(1'b1);
    hold_seq(4);

    miss_right();
    hold_seq(4);

    sstep("open_r2", S_PLAY, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    sstep("hit_and_tick", S_PLAY, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
    sstep("after_hit_tick", S_PLAY, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0);

    sstep("led_81", S_PLAY, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
    sstep("led_81_next", S_PLAY, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    sstep("led_03_next", S_PLAY, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

    miss_right();
    hold_seq(4);
    miss_right();
    hold_seq(2);

    // Asynchronous reset mid-POINT with ScoreL = 3, checked between clock edges.
    chk("pre_rst.score_l", 32'(score_l), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst.score_l", 32'(score_l), 32'd0);
    chk("arst.score_r", 32'(score_r), 32'd0);
    chk("arst.gameover", 32'(go), 32'd0);
    chk("arst.winner", 32'(win), 32'd0);
    chk("arst.an", 32'(an), 32'hF);
    chk("arst.seg", 32'(seg), 32'h7F);
    chk("arst.state", 32'(dut.state), 32'(S_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    exp_l = 4'd0; exp_r = 4'd0;
    sstep("post_rst_tick", S_IDLE, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    sstep("post_rst_tick2", S_IDLE, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

    sstep("begin2", S_PLAY, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    miss_left(1'b0);
    hold_seq(4);
    for (int k = 0; k < 7; k++) begin
      miss_right();
      hold_seq(4);
    end

    // Display scan with ScoreL = 7, ScoreR = 1.
    prev_d = -1; changes = 0; order_bad = 0; seen = 0;
    for (int i = 0; i < (1 << RB) + (1 << (RB - 2)) + 4; i++) begin
      @(posedge clk); #1;
      case (an)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b0111: d = 3;
        default: d = -1;
      endcase
      if (d < 0) order_bad++;
      else begin
        seen |= (1 << d);
        seg_d[d] = seg;
        if (prev_d >= 0 && d != prev_d) begin
          changes++;
          if (d != (prev_d + 1) % 4) order_bad++;
        end
        prev_d = d;
      end
    end
    chk("an_order_bad", 32'(order_bad), 32'd0);
    chk("an_seen", 32'(seen), 32'hF);
    chk("an_changes_ge4", 32'(changes >= 4), 32'd1);
    chk("dig3_seg", 32'(seg_d[3]), 32'(7'b0001111));
    chk("dig0_seg", 32'(seg_d[0]), 32'(seg_of(1)));
    chk("dig1_blank", 32'(seg_d[1]), 32'h7F);
    chk("dig2_blank", 32'(seg_d[2]), 32'h7F);

    // Two-point game on the second instance.
    rst = 1'b1; rst2 = 1'b0; use2 = 1'b1;
    win_sc = 4'd2; exp_l = 4'd0; exp_r = 4'd0;
    chk("rst2.an", 32'(an2), 32'hF);
    sstep("g2_begin", S_PLAY, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    miss_left(1'b0);
    hold_seq(4);
    miss_left(1'b0);
    chk("g2_gameover_in_point", 32'(go2), 32'd0);
    hold_seq(4);
    chk("g2_gameover", 32'(go2), 32'd1);
    chk("g2_winner", 32'(win2), 32'(2'b10));
    chk("g2_score_r", 32'(score_r2), 32'd2);
    sstep("g2_over_tick", S_OVER, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
    sstep("g2_over_tick2", S_OVER, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

    wait_an2(4'b0111, ok);
    chk("g2_wait_dig3", 32'(ok), 32'd1);
    chk("g2_dig3_blank", 32'(seg2), 32'h7F);
    wait_an2(4'b1110, ok);
    chk("g2_wait_dig0", 32'(ok), 32'd1);
    chk("g2_dig0_seg", 32'(seg2), 32'(seg_of(2)));

    exp_l = 4'd0; exp_r = 4'd0;
    sstep("g2_restart", S_PLAY, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("g2_restart_go", 32'(go2), 32'd0);
    chk("g2_restart_winner", 32'(win2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_scoreboard.md
PONG_SCOREBOARD -- requirements
Module: pong_scoreboard

Interface
REQ-001 Parameter WIN_SCORE, default 9: score at which a game ends; legal range 1..9.
REQ-002 Parameter POINT_HOLD, default 4: number of Tick pulses spent in POINT before play resumes.
REQ-003 Parameter REFRESH_BITS, default 17: width of the display refresh counter.
REQ-004 The port list SHALL be exactly as REQ-005 to REQ-016: one clock, Clk; reset Rst is asynchronous and active-high.
REQ-005 Clk  input  1  system clock; all state changes on its rising edge.
REQ-006 Rst  input  1  asynchronous active-high reset.
REQ-007 Tick  input  1  one-Clk-wide game-step enable from the clock divider.
REQ-008 Led  input  8  ball pattern from the light pattern generator; bit 7 is the left end, bit 0 is the right end.
REQ-009 HitL  input  1  synchronized single-cycle left-player pulse.
REQ-010 HitR  input  1  synchronized single-cycle right-player pulse.
REQ-011 Begin  input  1  level; starts a new game from IDLE or OVER.
REQ-012 ScoreL, ScoreR  output  4 each  binary scores.
REQ-013 Seg  output  7  segments a..g, active-low.
REQ-014 An  output  4  digit anodes, active-low.
REQ-015 GameOver  output  1  high while in OVER.
REQ-016 Winner  output  2  winning side: 01 = left, 10 = right, 00 = none.

Function
REQ-017 The FSM SHALL have states IDLE, PLAY, POINT and OVER, encoded as 2 bits.
REQ-018 IDLE -> PLAY when Begin = 1; both scores clear to 0 on this transition.
REQ-019 In PLAY, a Tick with Led == 8'h80 SHALL open the left window; a Tick with Led == 8'h01 SHALL open the right window; at most one window is open at a time.
REQ-020 A HitL pulse while the left window is open SHALL close that window with no score change; the HitR pulse behaves the same way for the right window.
REQ-021 If the next Tick arrives with a window still open (no hit), the opposite side SHALL score +1, the window SHALL close, and the FSM SHALL go to POINT in that same cycle.
REQ-022 A hit and a Tick in the same cycle SHALL count as a hit (the hit wins).
REQ-023 HitL or HitR outside an open window, or the wrong side's hit, SHALL be ignored.
REQ-024 In POINT, Tick pulses SHALL be counted; after the POINT_HOLD-th Tick the FSM goes to PLAY, or to OVER if either score == WIN_SCORE.
REQ-025 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-026 In OVER, GameOver = 1 and Winner marks the side with score == WIN_SCORE; a Begin = 1 SHALL clear both scores and return the FSM to PLAY.
REQ-027 Led values that are not one-hot SHALL NOT open any window.
REQ-028 The display SHALL use a free-running REFRESH_BITS counter whose top 2 bits select the digit.
REQ-029 Digit 3 (An = 0111) SHALL show ScoreL, digit 0 (An = 1110) SHALL show ScoreR, and digits 1 and 2 SHALL be blank (Seg = 7'h7F).
REQ-030 In OVER, the loser's digit SHALL be blanked.
REQ-031 Seg and An SHALL be registered, giving 1 Clk of latency from the digit select.
REQ-032 The 7-segment decode SHALL cover 0..9; values 10..15 SHALL display blank.

Reset
REQ-033 When Rst = 1, asynchronously: state = IDLE, ScoreL = ScoreR = 0, windows closed, hold and refresh counters = 0, GameOver = 0, Winner = 00, An = 4'hF, Seg = 7'h7F.
REQ-034 Rst asserted mid-PLAY or mid-POINT SHALL discard any pending point; after release the FSM SHALL wait in IDLE for Begin.

Verification
REQ-035 Begin pulse, then a Tick with Led = 8'h80, HitL 3 Clk later, then the next Tick -> scores stay 0/0 and state = PLAY.
REQ-036 Tick with Led = 8'h01 and no HitR, then the next Tick -> ScoreL = 1 in the same cycle, state = POINT, and after 4 Ticks state = PLAY.
REQ-037 HitR and Tick coincide while the right window is open -> no score change.
REQ-038 With WIN_SCORE = 2, two left misses -> ScoreR = 2, and after the hold GameOver = 1, Winner = 10, and digit 3 is blanked.
REQ-039 Rst asserted while in POINT with ScoreL = 3 -> all outputs return to their reset values immediately, without waiting for a Clk edge.
REQ-040 Over 2^(REFRESH_BITS) Clk cycles, An SHALL cycle through 1110, 1101, 1011, 0111, and with ScoreL = 7 digit 3 SHALL show Seg = 7'b0001111 (abc lit).
